hwag_coil_sched: RTL
====================

Name: hwag_coil_sched

Overview:
- Parametrised N-channel ignition coil scheduler.
- Sits after the HWAG core and angle counter. Takes the master angle count and its step strobe, and drives N coil outputs.
- Per channel: phase offset, double-buffered charge/ignition angles, maximum-dwell timeout, sticky overrun flag.
- Supersedes the single hard-wired coil channel in the top level. Adds channel count, phase offsets, dwell timeout and host writes.

Parameters:
- N_CH, 4, number of coil channels (>=1).
- AW, 24, angle width in bits.
- TW, 24, dwell timeout counter width.
- MAXACR, 3839, last valid angle value; the angle wraps to 0 after it.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- ena  in  1  global enable; when 0, all sequential state except shadow writes holds
- hwag_start  in  1  angle sync valid; 0 = not synchronised
- acnt_step  in  1  one-clk pulse: acnt_in advanced this cycle
- acnt_in  in  AW  master angle count, 0..MAXACR
- edge0  in  1  tooth strobe; safe point for shadow-to-active transfer
- phase_ofs  in  N_CH*AW  static per-channel phase offset; channel k = bits [k*AW +: AW]
- wr_en  in  1  shadow write strobe
- wr_ch  in  CHW  target channel (CHW = max(1,$clog2(N_CH)))
- wr_charge  in  AW  charge angle
- wr_ign  in  AW  ignition angle
- dwell_max  in  TW  max charge time in clk cycles; 0 disables the timeout
- flag_clr  in  1  clears all overrun flags
- coil_out  out  N_CH  coil drive, 1 = charging
- ovr_flag  out  N_CH  sticky dwell-timeout flag
- pending  out  N_CH  shadow written, not yet transferred

Behaviour:
- Reset (nrst=0, async): coil_out=0, ovr_flag=0, pending=0; all shadow/active angles=0; local angle=0; dwell counters=0; states=WAIT.
- Local angle, registered, 1 clk latency: sum = acnt_in + ofs_k (AW+1 bits). loc_k = sum - (MAXACR+1) if sum > MAXACR, else sum. Offsets > MAXACR are illegal; the block does not check them.
- step_d = acnt_step delayed 1 clk, aligned with loc_k. All angle events are qualified by step_d, so there is exactly one event per angle value.
- Shadow write: wr_en with wr_ch<N_CH loads shadow charge/ign and sets pending[wr_ch]. wr_ch>=N_CH is ignored. Writes are accepted even when ena=0.
- Transfer: ena & edge0 & pending[k] & state_k==WAIT copies shadow to active next clk and clears pending[k].
  - A write to the same channel in the same cycle: active gets the old shadow, shadow gets the new data, pending stays 1.
- Per-channel FSM (advances only when ena=1):
  - WAIT: coil=0. step_d & loc==act_charge & loc!=act_ign -> CHARGE, dwell cnt cleared.
  - CHARGE: coil=1, cnt increments each clk and saturates at all-ones.
  - CHARGE -> WAIT, coil=0, on step_d & loc==act_ign (normal spark).
  - CHARGE -> WAIT, coil=0, ovr_flag[k] set, when dwell_max!=0 & cnt==dwell_max-1 (timeout).
  - If ignition and timeout occur in the same clk: treat as normal spark, flag not set.
  - act_charge==act_ign: the channel never fires.
- coil_out is a registered FSM output. It rises 1 clk after the step_d that matched, i.e. 2 clk after acnt_step.
- Timeout length: coil_out is high for exactly dwell_max clks.
- hwag_start=0 (synchronous, has priority over ena): all FSMs -> WAIT, coil_out=0, dwell counters cleared, pending and shadows retained, ovr_flag retained.
- flag_clr: clears all ovr_flag next clk. A set in the same clk wins.
- Wrap: loc recomputes modulo MAXACR+1. A charge angle near MAXACR with an ignition angle near 0 must work across the wrap.
- Async reset mid-charge: coil_out drops immediately.

Decomposition:
- Package hwag_coil_pkg: state enum (WAIT, CHARGE), function for the wrapped add.
- Sub-module hwag_coil_chan: one channel (local angle add, shadow/active regs, FSM, dwell counter).
- The top instantiates N_CH channels in a generate loop and decodes wr_ch.

Test Plan:
- Basic fire: ofs0=0, charge=100, ign=200, dwell_max=0, step acnt 0..3839 -> coil_out[0] rises 2 clk after acnt_step to 100 and falls 2 clk after acnt_step to 200.
- Phase + wrap: ofs1=1920, charge=3800, ign=40 -> coil_out[1] high from acnt 1880 to 1960 (local 3800 wraps to 40); the channel's loc hits 0 at acnt 1920.
- Timeout: charge=100, ign=200, dwell_max=50, steps every 10 clk -> coil high exactly 50 clk, ovr_flag[0]=1, no second pulse in that revolution; flag_clr -> 0.
- Double buffer: write ch2 (500,600) while CHARGE on old (300,400) -> pending[2]=1 until the first edge0 after ignition; the next revolution fires at 500/600.
- Sync loss: hwag_start drops mid-charge -> coil_out=0 next clk, pending retained, normal firing after hwag_start returns.
- Reset/corner: nrst low mid-charge -> all outputs 0 asynchronously. charge==ign -> no pulse. wr_ch=N_CH -> no state change.

Source files
------------

// File: rtl/hwag_coil_pkg.sv
// Shared definitions for the HWAG ignition coil scheduler.
// Contents:
//   ST_WAIT / ST_CHARGE - per-channel FSM state encodings
//   wrap_add()          - modulo-(maxacr+1) add used to build each channel's local angle
package hwag_coil_pkg;

  localparam logic [0:0] ST_WAIT   = 1'b0;
  localparam logic [0:0] ST_CHARGE = 1'b1;

  // Adds two angles that are each within 0..maxacr and folds the result back into
  // the same range. One extra bit of headroom holds the carry before folding, so
  // angles up to 32 bits wide are supported. Callers truncate to their own width.
  function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] maxacr);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = {1'b0, maxacr};
    if (sum > lim) wrap_add = 32'(sum - (lim + 33'd1));
    else           wrap_add = sum[31:0];
  endfunction

endpackage

// File: rtl/hwag_coil_chan.sv
// One ignition coil channel.
// Builds a phase-shifted local angle from the master angle. Holds double-buffered
// charge/ignition angles. Runs the WAIT/CHARGE FSM with a maximum-dwell timeout.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   ena                  global enable (shadow writes ignore it)
//   hwag_start           angle sync valid; 0 forces WAIT
//   acnt_step, acnt_in   master angle step strobe and value
//   edge0                safe point for shadow-to-active transfer
//   ofs                  static phase offset of this channel
//   wr_sel               shadow write strobe already decoded for this channel
//   wr_charge, wr_ign    shadow write data
//   dwell_max            maximum charge time in clocks, 0 = no limit
//   flag_clr             clears the overrun flag
//   coil_out, ovr_flag, pending  channel outputs
module hwag_coil_chan
  import hwag_coil_pkg::*;
#(
  parameter int AW     = 24,
  parameter int TW     = 24,
  parameter int MAXACR = 3839
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          ena,
  input  logic          hwag_start,
  input  logic          acnt_step,
  input  logic [AW-1:0] acnt_in,
  input  logic          edge0,
  input  logic [AW-1:0] ofs,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_charge,
  input  logic [AW-1:0] wr_ign,
  input  logic [TW-1:0] dwell_max,
  input  logic          flag_clr,
  output logic          coil_out,
  output logic          ovr_flag,
  output logic          pending
);

  logic [AW-1:0] loc_d, loc_q;
  logic          stp_d, stp_q;
  logic [AW-1:0] sh_chg_d, sh_chg_q, sh_ign_d, sh_ign_q;
  logic [AW-1:0] act_chg_d, act_chg_q, act_ign_d, act_ign_q;
  logic          pending_d, pending_q;
  logic [0:0]    state_d, state_q;
  logic          coil_d, coil_q;
  logic [TW-1:0] cnt_d, cnt_q;
  logic          ovr_d, ovr_q;
  logic          hit_chg, hit_ign, tmo, xfer, ovr_set;

  always_comb begin
    // Local angle and the delayed step strobe that qualifies it
    loc_d = loc_q;
    stp_d = stp_q;
    if (ena) begin
      loc_d = AW'(wrap_add(32'(acnt_in), 32'(ofs), 32'(MAXACR)));
      stp_d = acnt_step;
    end

    // Angle events only count on the cycle the local angle actually advanced.
    // A channel with equal charge and ignition angles never fires.
    hit_chg = stp_q && (loc_q == act_chg_q) && (loc_q != act_ign_q);
    hit_ign = stp_q && (loc_q == act_ign_q);
    tmo     = (dwell_max != '0) && (cnt_q == dwell_max - TW'(1));

    // Shadow/active double buffer. On a write and a transfer in the same cycle,
    // active takes the old shadow and pending remains set for the new data.
    xfer      = ena && edge0 && pending_q && (state_q == ST_WAIT);
    sh_chg_d  = wr_sel ? wr_charge : sh_chg_q;
    sh_ign_d  = wr_sel ? wr_ign    : sh_ign_q;
    act_chg_d = xfer ? sh_chg_q : act_chg_q;
    act_ign_d = xfer ? sh_ign_q : act_ign_q;
    pending_d = wr_sel ? 1'b1 : (xfer ? 1'b0 : pending_q);

    // Coil FSM; loss of sync overrides the enable
    state_d = state_q;
    coil_d  = coil_q;
    cnt_d   = cnt_q;
    ovr_set = 1'b0;
    if (!hwag_start) begin
      state_d = ST_WAIT;
      coil_d  = 1'b0;
      cnt_d   = '0;
    end else if (ena) begin
      case (state_q)
        ST_WAIT: begin
          coil_d = 1'b0;
          if (hit_chg) begin
            state_d = ST_CHARGE;
            coil_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        default: begin
          // A spark on the same clock as the timeout is a normal spark
          if (hit_ign) begin
            state_d = ST_WAIT;
            coil_d  = 1'b0;
          end else if (tmo) begin
            state_d = ST_WAIT;
            coil_d  = 1'b0;
            ovr_set = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      endcase
    end

    // Sticky overrun flag; a new timeout beats a simultaneous clear
    ovr_d = ovr_q;
    if (ena && flag_clr) ovr_d = 1'b0;
    if (ovr_set)         ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      loc_q     <= '0;
      stp_q     <= 1'b0;
      sh_chg_q  <= '0;
      sh_ign_q  <= '0;
      act_chg_q <= '0;
      act_ign_q <= '0;
      pending_q <= 1'b0;
      state_q   <= ST_WAIT;
      coil_q    <= 1'b0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      loc_q     <= loc_d;
      stp_q     <= stp_d;
      sh_chg_q  <= sh_chg_d;
      sh_ign_q  <= sh_ign_d;
      act_chg_q <= act_chg_d;
      act_ign_q <= act_ign_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      coil_q    <= coil_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign coil_out = coil_q;
  assign ovr_flag = ovr_q;
  assign pending  = pending_q;

endmodule

// File: rtl/hwag_coil_sched.sv
// N-channel ignition coil scheduler driven by the HWAG master angle count.
// The block decodes host shadow writes to one channel and fans the shared angle,
// sync, enable and dwell settings out to N_CH identical channels.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   ena, hwag_start           global enable, angle sync valid
//   acnt_step, acnt_in        master angle step strobe and count
//   edge0                     tooth strobe used as the shadow transfer point
//   phase_ofs                 per-channel offsets, channel k at [k*AW +: AW]
//   wr_en, wr_ch, wr_charge, wr_ign   host shadow write
//   dwell_max                 maximum charge time in clocks (0 = off)
//   flag_clr                  clears all overrun flags
//   coil_out, ovr_flag, pending       per-channel outputs
module hwag_coil_sched
  import hwag_coil_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int AW     = 24,
  parameter int TW     = 24,
  parameter int MAXACR = 3839,
  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena,
  input  logic             hwag_start,
  input  logic             acnt_step,
  input  logic [AW-1:0]    acnt_in,
  input  logic             edge0,
  input  logic [N_CH*AW-1:0] phase_ofs,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [AW-1:0]    wr_charge,
  input  logic [AW-1:0]    wr_ign,
  input  logic [TW-1:0]    dwell_max,
  input  logic             flag_clr,
  output logic [N_CH-1:0]  coil_out,
  output logic [N_CH-1:0]  ovr_flag,
  output logic [N_CH-1:0]  pending
);

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_ch
      // Channel numbers at or above N_CH match no instance and are dropped
      logic wr_sel;
      assign wr_sel = wr_en && (wr_ch == CHW'(k));

      hwag_coil_chan #(
        .AW     (AW),
        .TW     (TW),
        .MAXACR (MAXACR)
      ) u_chan (
        .clk        (clk),
        .nrst       (nrst),
        .ena        (ena),
        .hwag_start (hwag_start),
        .acnt_step  (acnt_step),
        .acnt_in    (acnt_in),
        .edge0      (edge0),
        .ofs        (phase_ofs[k*AW +: AW]),
        .wr_sel     (wr_sel),
        .wr_charge  (wr_charge),
        .wr_ign     (wr_ign),
        .dwell_max  (dwell_max),
        .flag_clr   (flag_clr),
        .coil_out   (coil_out[k]),
        .ovr_flag   (ovr_flag[k]),
        .pending    (pending[k])
      );
    end
  endgenerate

endmodule
